// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared BCD definitions used by the display path and the BCD-to-binary converter.
// Holds the controller state type, digit constants and default sizes.
package bcd_to_bin_seq_pkg;

  localparam int DIGITS_DEF = 10;
  localparam int WIDTH_DEF  = 32;

  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ        = 4'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction step of reverse double-dabble: after a right shift,
// a digit that picked up the half-weight of the digit above (>= 8) loses 3.
module bcd_digit_adjust
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in - BCD_ADJ) : digit_in;
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// One right shift plus digit correction per clock; flags bad digits and overflow.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int WIDTH  = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      bin_out,
  output logic                  overflow,
  output logic                  bad_digit
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   bin_out_q, bin_out_d;
  logic               overflow_q, overflow_d;
  logic               bad_digit_q, bad_digit_d;

  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_adj;
  logic [WIDTH-1:0]   bin_shift;
  logic [DIGITS-1:0]  digit_bad;
  logic               any_bad;

  // The LSB of the BCD field falls into the MSB of the binary field.
  assign bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
  assign bin_shift = {bcd_q[0], bin_q[WIDTH-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adjust u_adjust (
      .digit_in  (bcd_shift[4*g +: 4]),
      .digit_out (bcd_adj[4*g +: 4])
    );
    assign digit_bad[g] = (bcd_in[4*g +: 4] > BCD_MAX);
  end

  assign any_bad = |digit_bad;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  // The working register is a few dozen flops, not a RAM, so it is reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      bin_out_q   <= '0;
      overflow_q  <= 1'b0;
      bad_digit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      bin_out_q   <= bin_out_d;
      overflow_q  <= overflow_d;
      bad_digit_q <= bad_digit_d;
    end
  end

  // NOTE: every variable gets a hold/default value before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    bin_out_d   = bin_out_q;
    overflow_d  = overflow_q;
    bad_digit_d = bad_digit_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (any_bad) begin
            done_d      = 1'b1;
            bad_digit_d = 1'b1;
            bin_out_d   = '0;
            overflow_d  = 1'b0;
          end else begin
            bcd_d       = bcd_in;
            bin_d       = '0;
            cnt_d       = '0;
            overflow_d  = 1'b0;
            bad_digit_d = 1'b0;
            state_d     = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = bin_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Anything left in the BCD field did not fit in WIDTH bits.
          bin_out_d   = bin_shift;
          overflow_d  = |bcd_adj;
          bad_digit_d = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == SHIFT);
    done      = done_q;
    bin_out   = bin_out_q;
    overflow  = overflow_q;
    bad_digit = bad_digit_q;
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: table of conversions plus hand-written
// sequences for start-during-busy, back-to-back and mid-conversion reset.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 10;
  localparam int WIDTH  = 32;
  localparam int LAT    = WIDTH; // edges after the accepting edge until done is visible

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [4*DIGITS-1:0] bcd_in;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    bin_out;
  logic                overflow;
  logic                bad_digit;

  int n_cmp  = 0;
  int n_fail = 0;
  int overlap_cnt = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .bin_out   (bin_out),
    .overflow  (overflow),
    .bad_digit (bad_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy === 1'b1 && done === 1'b1) overlap_cnt++;
  end

  typedef struct {
    string               name;
    logic [4*DIGITS-1:0] bcd;
    logic [WIDTH-1:0]    bin;
    logic                ovf;
    logic                bad;
    int                  lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [4*DIGITS-1:0] bcd);
    @(negedge clk);
    bcd_in = bcd;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int first_done;
    int second_done;
    int done_cnt;

    vecs[0] = '{"zero",      40'h00_0000_0000, 32'h0000_0000, 1'b0, 1'b0, LAT};
    vecs[1] = '{"mixed",     40'h12_3456_7890, 32'h4996_02D2, 1'b0, 1'b0, LAT};
    vecs[2] = '{"max32",     40'h42_9496_7295, 32'hFFFF_FFFF, 1'b0, 1'b0, LAT};
    vecs[3] = '{"ovf_2p32",  40'h42_9496_7296, 32'h0000_0000, 1'b1, 1'b0, LAT};
    vecs[4] = '{"ovf_all9",  40'h99_9999_9999, 32'h540B_E3FF, 1'b1, 1'b0, LAT};
    vecs[5] = '{"bad_low",   40'h00_0000_00A5, 32'h0000_0000, 1'b0, 1'b1, 0};
    vecs[6] = '{"bad_high",  40'hF0_0000_0001, 32'h0000_0000, 1'b0, 1'b1, 0};

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    #12;
    check("reset_outputs", {busy, done, overflow, bad_digit, bin_out}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // A normal conversion first, so the bad-digit vectors must actively clear bin_out.
    for (int i = 0; i < 7; i++) begin
      do_start(vecs[i].bcd);
      if (vecs[i].bad) check({vecs[i].name, "_busy_after_start"}, busy, 1'b0);
      else             check({vecs[i].name, "_busy_after_start"}, busy, 1'b1);
      wait_done(lat);
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      check({vecs[i].name, "_bin_out"}, bin_out, vecs[i].bin);
      check({vecs[i].name, "_overflow"}, overflow, vecs[i].ovf);
      check({vecs[i].name, "_bad_digit"}, bad_digit, vecs[i].bad);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_done_one_cycle"}, {busy, done}, 2'b00);
      check({vecs[i].name, "_bin_out_held"}, bin_out, vecs[i].bin);
    end

    // Start pulses at iterations 5 and 20 are ignored; start held through the
    // done cycle is accepted at the edge that ends it.
    do_start(40'h12_3456_7890);
    first_done  = -1;
    second_done = -1;
    for (int e = 1; e <= 100; e++) begin
      @(negedge clk);
      bcd_in = (e >= 25) ? 40'h00_0000_0042 : 40'h00_0000_0001;
      start  = (e == 5) || (e == 20) ||
               (e >= 25 && (first_done < 0 || e <= first_done + 1));
      @(posedge clk);
      #1;
      if (first_done >= 0 && e == first_done + 1)
        check("b2b_busy_after_accept", {busy, done}, 2'b10);
      if (done === 1'b1) begin
        if (first_done < 0) begin
          first_done = e;
          check("b2b_first_bin_out", bin_out, 32'h4996_02D2);
        end else begin
          second_done = e;
          check("b2b_second_bin_out", bin_out, 32'h0000_002A);
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b_first_done_edge", first_done, LAT);
    check("b2b_done_spacing", second_done - first_done, WIDTH + 1);

    // Asynchronous reset in the middle of a conversion.
    do_start(40'h99_9999_9999);
    repeat (17) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {busy, done, overflow, bad_digit, bin_out}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    check("midreset_no_done_or_busy", done_cnt, 0);
    do_start(40'h00_0000_0042);
    wait_done(lat);
    check("post_reset_latency", lat, LAT);
    check("post_reset_bin_out", {overflow, bad_digit, bin_out}, {2'b00, 32'h0000_002A});

    check("busy_done_overlap", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
